multi_operand_adder_stream: RTL and testbench

- Parametrised successor of the two-operand socket-fed adder used in multi-FPGA co-simulation.
- Sums N_OPS operands of DWIDTH bits taken from one packed socket word.
- Configurable pipeline depth, signed or unsigned arithmetic, wrap or saturate mode.
- Full valid/ready handshake on both sides, overflow flag, and transaction counter; sits directly between socket_server_wrapper output (din) and input (dout).

---
 rtl/multi_operand_adder_stream.sv | 103 ++++++++++
 tb/tb_multi_operand_adder_stream.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_operand_adder_stream.sv
// Streaming adder: sums N_OPS packed operands through a PIPE_STAGES-deep
// valid/ready pipeline, with wrap or saturate result and an overflow flag.
module multi_operand_adder_stream #(
  parameter int DWIDTH      = 32,
  parameter int N_OPS       = 2,
  parameter int SIGNED      = 0,
  parameter int SATURATE    = 0,
  parameter int PIPE_STAGES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_OPS*DWIDTH-1:0] din,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic [DWIDTH-1:0]       dout,
  output logic                    dout_ovf,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic [31:0]             txn_count
);

  localparam int LOGN = $clog2(N_OPS);
  localparam int EW   = DWIDTH + LOGN;

  logic [PIPE_STAGES-1:0] stage_valid;
  logic [EW-1:0]          stage_sum [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] advance;
  logic                   room;
  logic [DWIDTH-1:0]      op_k;
  logic [EW-1:0]          op_ext;
  logic [EW-1:0]          in_sum;
  logic [EW-1:0]          result;
  logic                   take;

  // Exact sum in EW bits; this width cannot overflow for N_OPS operands.
  always_comb begin
    in_sum = '0;
    op_k   = '0;
    op_ext = '0;
    for (int k = 0; k < N_OPS; k++) begin
      op_k = din[k*DWIDTH +: DWIDTH];
      if (SIGNED != 0) op_ext = {{LOGN{op_k[DWIDTH-1]}}, op_k};
      else             op_ext = {{LOGN{1'b0}}, op_k};
      in_sum = in_sum + op_ext;
    end
  end

  // A stage moves on if any later stage is empty or the output is taken;
  // scanning from the tail keeps this free of a combinational self-loop.
  always_comb begin
    advance = '0;
    room    = dout_ready;
    for (int i = PIPE_STAGES - 1; i >= 0; i--) begin
      advance[i] = stage_valid[i] && room;
      room       = room || !stage_valid[i];
    end
  end

  assign din_ready = rst && (!stage_valid[0] || advance[0]);
  assign take      = din_valid && din_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_valid <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) stage_sum[i] <= '0;
      txn_count   <= '0;
    end else begin
      if (take) begin
        stage_valid[0] <= 1'b1;
        stage_sum[0]   <= in_sum;
      end else if (advance[0]) begin
        stage_valid[0] <= 1'b0;
      end
      for (int i = 1; i < PIPE_STAGES; i++) begin
        if (advance[i-1]) begin
          stage_valid[i] <= 1'b1;
          stage_sum[i]   <= stage_sum[i-1];
        end else if (advance[i]) begin
          stage_valid[i] <= 1'b0;
        end
      end
      if (dout_valid && dout_ready) txn_count <= txn_count + 32'd1;
    end
  end

  assign dout_valid = stage_valid[PIPE_STAGES-1];
  assign result     = stage_sum[PIPE_STAGES-1];

  // Range check and clamp act on the held last-stage sum, so dout stays stable during stalls.
  always_comb begin
    dout     = result[DWIDTH-1:0];
    dout_ovf = 1'b0;
    if (SIGNED != 0) begin
      dout_ovf = !((&result[EW-1:DWIDTH-1]) || !(|result[EW-1:DWIDTH-1]));
      if (SATURATE != 0 && dout_ovf)
        dout = result[EW-1] ? {1'b1, {(DWIDTH-1){1'b0}}} : {1'b0, {(DWIDTH-1){1'b1}}};
    end else begin
      dout_ovf = |result[EW-1:DWIDTH];
      if (SATURATE != 0 && dout_ovf) dout = '1;
    end
  end

endmodule

// File: tb/tb_multi_operand_adder_stream.sv
// Bench for multi_operand_adder_stream: vector tables on single-shot instances,
// scoreboarded streams for backpressure, throughput and mid-stream reset.
module tb_multi_operand_adder_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A: 32b unsigned wrap, B: 32b unsigned saturate (shared inputs), P=1
  logic [63:0] din_ab;
  logic        vin_ab, ordy_ab;
  logic        rdy_a, ovf_a, vout_a, rdy_b, ovf_b, vout_b;
  logic [31:0] dout_a, cnt_a, dout_b, cnt_b;
  // C: 8b signed saturate, 4 operands, P=2
  logic [31:0] din_c, cnt_c;
  logic        vin_c, ordy_c, rdy_c, ovf_c, vout_c;
  logic [7:0]  dout_c;
  // D: 8b unsigned wrap, 2 operands, P=3
  logic [15:0] din_d;
  logic        vin_d, oready_d, rdy_d, ovf_d, vout_d;
  logic [7:0]  dout_d;
  logic [31:0] cnt_d;
  // E: 16b signed wrap, 3 operands, P=2
  logic [47:0] din_e;
  logic        vin_e, oready_e, rdy_e, ovf_e, vout_e;
  logic [15:0] dout_e;
  logic [31:0] cnt_e;

  multi_operand_adder_stream #(.DWIDTH(32), .N_OPS(2), .SIGNED(0), .SATURATE(0), .PIPE_STAGES(1)) u_a (
    .clk(clk), .rst(rst), .din(din_ab), .din_valid(vin_ab), .din_ready(rdy_a),
    .dout(dout_a), .dout_ovf(ovf_a), .dout_valid(vout_a), .dout_ready(ordy_ab), .txn_count(cnt_a));
  multi_operand_adder_stream #(.DWIDTH(32), .N_OPS(2), .SIGNED(0), .SATURATE(1), .PIPE_STAGES(1)) u_b (
    .clk(clk), .rst(rst), .din(din_ab), .din_valid(vin_ab), .din_ready(rdy_b),
    .dout(dout_b), .dout_ovf(ovf_b), .dout_valid(vout_b), .dout_ready(ordy_ab), .txn_count(cnt_b));
  multi_operand_adder_stream #(.DWIDTH(8), .N_OPS(4), .SIGNED(1), .SATURATE(1), .PIPE_STAGES(2)) u_c (
    .clk(clk), .rst(rst), .din(din_c), .din_valid(vin_c), .din_ready(rdy_c),
    .dout(dout_c), .dout_ovf(ovf_c), .dout_valid(vout_c), .dout_ready(ordy_c), .txn_count(cnt_c));
  multi_operand_adder_stream #(.DWIDTH(8), .N_OPS(2), .SIGNED(0), .SATURATE(0), .PIPE_STAGES(3)) u_d (
    .clk(clk), .rst(rst), .din(din_d), .din_valid(vin_d), .din_ready(rdy_d),
    .dout(dout_d), .dout_ovf(ovf_d), .dout_valid(vout_d), .dout_ready(oready_d), .txn_count(cnt_d));
  multi_operand_adder_stream #(.DWIDTH(16), .N_OPS(3), .SIGNED(1), .SATURATE(0), .PIPE_STAGES(2)) u_e (
    .clk(clk), .rst(rst), .din(din_e), .din_valid(vin_e), .din_ready(rdy_e),
    .dout(dout_e), .dout_ovf(ovf_e), .dout_valid(vout_e), .dout_ready(oready_e), .txn_count(cnt_e));

  typedef struct {
    logic [63:0] din;
    logic [31:0] exp_a;
    logic        ovf_a;
    logic [31:0] exp_b;
    logic        ovf_b;
  } vec_ab_t;

  typedef struct {
    logic [31:0] din;
    logic [7:0]  exp;
    logic        ovf;
  } vec_c_t;

  vec_ab_t tab_ab [7];
  vec_c_t  tab_c  [11];

  function automatic logic [8:0] model_d(input logic [15:0] d);
    int s;
    s = int'(d[7:0]) + int'(d[15:8]);
    return {(s > 255), s[7:0]};
  endfunction

  function automatic logic [16:0] model_e(input logic [47:0] d);
    longint s;
    s = 0;
    for (int k = 0; k < 3; k++) s += longint'(shortint'(d[k*16 +: 16]));
    return {((s > 32767) || (s < -32768)), s[15:0]};
  endfunction

  // Scoreboard for D, with occupancy tracking for the ready and hold checks
  logic [8:0] exp_q_d [$];
  logic [8:0] exp_d;
  int         inflight_d = 0;
  int         got_d = 0;
  logic       prev_stall_d = 1'b0;
  logic [7:0] prev_dout_d = '0;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q_d.delete();
      inflight_d   = 0;
      prev_stall_d = 1'b0;
    end else begin
      if (prev_stall_d) check("d_hold", {vout_d, dout_d}, {1'b1, prev_dout_d});
      check("d_din_ready", rdy_d, (inflight_d < 3) || oready_d);
      if (vout_d && oready_d) begin
        check("d_expected_pending", exp_q_d.size() != 0, 1'b1);
        if (exp_q_d.size() != 0) begin
          exp_d = exp_q_d.pop_front();
          check("d_result", {ovf_d, dout_d}, exp_d);
        end
        inflight_d--;
        got_d++;
      end
      if (vin_d && rdy_d) begin
        exp_q_d.push_back(model_d(din_d));
        inflight_d++;
      end
      prev_stall_d = vout_d && !oready_d;
      prev_dout_d  = dout_d;
    end
  end

  // Scoreboard for E; reset discards everything still pending
  logic [16:0] exp_q_e [$];
  logic [16:0] exp_e;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q_e.delete();
    end else begin
      if (vout_e && oready_e) begin
        check("e_expected_pending", exp_q_e.size() != 0, 1'b1);
        if (exp_q_e.size() != 0) begin
          exp_e = exp_q_e.pop_front();
          check("e_result", {ovf_e, dout_e}, exp_e);
        end
      end
      if (vin_e && rdy_e) exp_q_e.push_back(model_e(din_e));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    tab_ab[0] = '{{32'd7, 32'd5},                 32'd12,        1'b0, 32'd12,        1'b0};
    tab_ab[1] = '{{32'h2, 32'hFFFF_FFFF},         32'h1,         1'b1, 32'hFFFF_FFFF, 1'b1};
    tab_ab[2] = '{{32'h1, 32'hFFFF_FFFF},         32'h0,         1'b1, 32'hFFFF_FFFF, 1'b1};
    tab_ab[3] = '{{32'h1, 32'hFFFF_FFFE},         32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0};
    tab_ab[4] = '{{32'h0, 32'h0},                 32'h0,         1'b0, 32'h0,         1'b0};
    tab_ab[5] = '{{32'h8000_0000, 32'h8000_0000}, 32'h0,         1'b1, 32'hFFFF_FFFF, 1'b1};
    tab_ab[6] = '{{32'h1111_1111, 32'h1234_5678}, 32'h2345_6789, 1'b0, 32'h2345_6789, 1'b0};

    // operands packed {op3, op2, op1, op0}
    tab_c[0]  = '{32'h00EC_3264, 8'h7F, 1'b1};  // 100+50-20 = 130
    tab_c[1]  = '{32'h000A_CE9C, 8'h80, 1'b1};  // -100-50+10 = -140
    tab_c[2]  = '{32'h0001_FB03, 8'hFF, 1'b0};  // 3-5+1 = -1
    tab_c[3]  = '{32'h00FF_FB03, 8'hFD, 1'b0};  // 3-5-1 = -3
    tab_c[4]  = '{32'h0000_007F, 8'h7F, 1'b0};
    tab_c[5]  = '{32'h0000_017F, 8'h7F, 1'b1};  // 128
    tab_c[6]  = '{32'h0000_0080, 8'h80, 1'b0};
    tab_c[7]  = '{32'h0000_FF80, 8'h80, 1'b1};  // -129
    tab_c[8]  = '{32'h7F7F_7F7F, 8'h7F, 1'b1};  // 508
    tab_c[9]  = '{32'h8080_8080, 8'h80, 1'b1};  // -512
    tab_c[10] = '{32'hFFFF_FFFF, 8'hFC, 1'b0};  // -4

    rst = 1'b0;
    din_ab = '0; vin_ab = 1'b0; ordy_ab = 1'b0;
    din_c = '0;  vin_c = 1'b0;  ordy_c = 1'b0;
    din_d = '0;  vin_d = 1'b0;  oready_d = 1'b0;
    din_e = '0;  vin_e = 1'b0;  oready_e = 1'b0;
    step(); step();
    @(negedge clk);
    check("rst_din_ready", rdy_a, 1'b0);
    check("rst_dout_valid", vout_a, 1'b0);
    check("rst_dout", dout_a, 32'h0);
    check("rst_ovf", ovf_a, 1'b0);
    check("rst_txn_count", cnt_a, 32'h0);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", rdy_a, 1'b1);
    step();

    for (int i = 0; i < 7; i++) begin
      din_ab = tab_ab[i].din; vin_ab = 1'b1; ordy_ab = 1'b1;
      @(negedge clk);
      check("ab_din_ready", rdy_a, 1'b1);
      step();
      vin_ab = 1'b0;
      @(negedge clk);
      check("a_valid_lat1", vout_a, 1'b1);
      check("a_dout", dout_a, tab_ab[i].exp_a);
      check("a_ovf", ovf_a, tab_ab[i].ovf_a);
      check("b_valid_lat1", vout_b, 1'b1);
      check("b_dout", dout_b, tab_ab[i].exp_b);
      check("b_ovf", ovf_b, tab_ab[i].ovf_b);
      step();
      @(negedge clk);
      check("a_drained", vout_a, 1'b0);
      if (i == 0) check("a_count_first", cnt_a, 32'd1);
      step();
    end
    check("a_count_total", cnt_a, 32'd7);
    check("b_count_total", cnt_b, 32'd7);

    for (int i = 0; i < 11; i++) begin
      din_c = tab_c[i].din; vin_c = 1'b1; ordy_c = 1'b1;
      @(negedge clk);
      check("c_din_ready", rdy_c, 1'b1);
      step();
      vin_c = 1'b0;
      @(negedge clk);
      check("c_not_early", vout_c, 1'b0);
      step();
      @(negedge clk);
      check("c_valid_lat2", vout_c, 1'b1);
      check("c_dout", dout_c, tab_c[i].exp);
      check("c_ovf", ovf_c, tab_c[i].ovf);
      step();
    end
    check("c_count_total", cnt_c, 32'd11);

    // backpressure: operands (i, i), dout_ready cycling 1,0,0,1
    fork
      begin
        for (int c = 0; c < 80; c++) begin
          oready_d = (c % 4 == 0) || (c % 4 == 3);
          step();
        end
        oready_d = 1'b1;
      end
      begin
        logic acc;
        for (int i = 0; i < 10; i++) begin
          din_d = {i[7:0], i[7:0]}; vin_d = 1'b1;
          acc = 1'b0;
          for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk);
            acc = rdy_d;
            step();
          end
          check("d_accept", acc, 1'b1);
        end
        vin_d = 1'b0;
      end
    join
    for (int t = 0; t < 40 && got_d < 10; t++) step();
    step();
    check("d_results_seen", got_d, 10);
    check("d_txn_count", cnt_d, 32'd10);

    // full throughput on E: 20 back-to-back inputs
    oready_e = 1'b1; vin_e = 1'b1;
    din_e = {16'h0001, 16'h7FFF, 16'h7FFF};
    seen = 0;
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      check("e_valid_window", vout_e, (n >= 2) && (n <= 21));
      if (vout_e) seen++;
      if (n == 20) check("e_results_by_20", seen, 19);
      step();
      if (n < 19) din_e = {16'($urandom), 16'($urandom), 16'($urandom)};
      else vin_e = 1'b0;
    end
    check("e_txn_count", cnt_e, 32'd20);

    // mid-stream reset with two results held in flight
    oready_e = 1'b0; vin_e = 1'b1;
    din_e = {16'd0, 16'd5, 16'd6};
    step();
    din_e = {16'd0, 16'd7, 16'd8};
    step();
    vin_e = 1'b0;
    @(negedge clk);
    check("e_inflight_valid", vout_e, 1'b1);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("e_rst_din_ready", rdy_e, 1'b0);
    step();
    rst = 1'b1; oready_e = 1'b1;
    @(negedge clk);
    check("e_rst_valid", vout_e, 1'b0);
    check("e_rst_txn", cnt_e, 32'd0);
    check("e_rst_ready_after", rdy_e, 1'b1);
    step();
    din_e = {16'd0, 16'd1, 16'd1}; vin_e = 1'b1;
    step();
    vin_e = 1'b0;
    @(negedge clk);
    check("e_post_rst_no_stale", vout_e, 1'b0);
    step();
    @(negedge clk);
    check("e_post_rst_valid", vout_e, 1'b1);
    check("e_post_rst_dout", dout_e, 16'd2);
    step();
    step();
    check("e_post_rst_txn", cnt_e, 32'd1);
    check("d_queue_empty", exp_q_d.size(), 0);
    check("e_queue_empty", exp_q_e.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
